pipe_add_sub: RTL and testbench
===============================

# pipe_add_sub

Parametrised, pipelined two's-complement adder/subtractor: the sequential successor of the 4-bit combinational ripple adder. It splits a WIDTH-bit operation into STAGES equal chunks, adding one chunk per cycle with a registered carry between stages. Throughput is one operation per cycle under a valid/ready handshake with full backpressure. It sits between operand producers and result consumers in datapaths where a flat WIDTH-bit ripple carry would not close timing.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of STAGES.
- STAGES, 4: pipeline depth and chunk count. Chunk width CW = WIDTH/STAGES, with CW ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in. Used only when sub=0.
- sub  in  1  0 computes a+b+cin; 1 computes a−b.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. When sub=1, cout=1 means no borrow.
- ovf  out  1  signed overflow.

## Operation
- Effective operand: b_eff = sub ? ~b : b. Effective carry-in: c0 = sub ? 1 : cin.
- Stage k (0..STAGES−1):
  - Adds chunk k of a and b_eff plus the carry from stage k−1 (c0 for stage 0).
  - Registers its CW-bit partial sum and its carry-out.
  - Upper operand chunks, and the lower sum chunks already computed, travel alongside in skew registers.
- Each stage holds a valid bit, so bubbles propagate as invalid slots.
- Final stage outputs:
  - sum: concatenation of all chunks.
  - cout: carry out of the last chunk.
  - ovf = (a[W−1] == b_eff[W−1]) && (sum[W−1] != a[W−1]). a and b_eff MSBs are carried to the final stage for this.
- Advance condition: adv = !out_valid || out_ready.
  - When adv=1, every stage shifts by one.
  - When adv=0, every stage holds, including bubbles. Bubbles are not compressed.
- in_ready = adv. This is combinational from out_ready and out_valid.
- A beat is accepted when in_valid && in_ready. If in_valid=0 while adv=1, a bubble enters stage 0.
- Width rules:
  - All arithmetic is modulo 2^WIDTH; cout and ovf report the excess.
  - Each chunk add is CW+1 bits wide.
- Results leave in exactly the order operands were accepted. No beat is dropped or duplicated.

## Timing
- Latency: an operand accepted at edge n appears with out_valid=1 after edge n+STAGES, provided there is no stall.
- Each cycle with adv=0 adds one cycle of latency.
- Throughput: one beat per cycle while out_ready=1.
- Reset state, effective at the first edge with rst=1:
  - all stage valid bits = 0, so out_valid=0 and in_ready=1;
  - sum=0, cout=0, ovf=0;
  - all data registers = 0.
- Reset mid-operation: all in-flight beats are discarded, with no partial output. A beat presented in the reset cycle is not accepted.
- Stall: while out_valid && !out_ready, sum/cout/ovf stay stable and in_ready=0.
- Simultaneous accept and output in the same cycle: both occur, and occupancy is unchanged.
- STAGES=1 degenerates to a single registered adder with latency 1.

## Structure
- Shared package `pipe_add_pkg`:
  - OP_ADD=1'b0 and OP_SUB=1'b1;
  - the CW derivation as a constant function;
  - elaboration-time check WIDTH % STAGES == 0.
- Sub-module `add_chunk`:
  - CW-bit combinational adder with ports a, b, ci, s, co;
  - instantiated STAGES times in a generate loop.
- Top level holds the valid chain, skew registers and handshake logic.

## Test plan
All scenarios use WIDTH=16, STAGES=4 unless stated.
- Basic add: a=0x0003, b=0x0005, cin=0, sub=0 → sum=0x0008, cout=0, ovf=0, with out_valid exactly 4 cycles after accept.
- Carry across all chunks: 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1.
- Subtract: 0x0005−0x0007 → 0xFFFE, cout=0, ovf=0. Also 0x8000−0x0001 → 0x7FFF, cout=1, ovf=1.
- Backpressure: stream 8 back-to-back random beats; drop out_ready for 3 cycles mid-stream → in_ready=0 during the stall, outputs held stable, all 8 results correct and in order.
- Bubbles and reset: inject a 2-cycle in_valid gap, then assert rst with 3 beats in flight → out_valid=0 from the next cycle, no stale results afterward, and a fresh beat after reset completes in 4 cycles.
- Parameter sweep: WIDTH=8/STAGES=1 and WIDTH=32/STAGES=8, 1000 random beats each, checked against a reference model → zero mismatches.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// Shared definitions for the pipelined adder/subtractor: opcode encoding and
// chunk geometry helpers used when elaborating the stage chain.
package pipe_add_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int chunkWidth(input int width, input int stages);
    return width / stages;
  endfunction

  // A legal configuration splits the operand into equal, non-empty chunks.
  function automatic bit configOk(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_add_sub_add_chunk.sv
// One chunk of the carry chain: CW-bit add with carry in and carry out.
module add_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement adder/subtractor: one CW-bit chunk per stage with
// a registered carry, valid bit per stage, and whole-pipe stall on backpressure.
module pipe_add_sub
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = chunkWidth(WIDTH, STAGES);

  if (!configOk(WIDTH, STAGES)) begin : gCfgCheck
    $error("pipe_add_sub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] bEff;
  logic             c0;

  assign bEff     = (sub == OP_SUB) ? ~b : b;
  assign c0       = (sub == OP_SUB) ? 1'b1 : cin;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage k consumes the low chunk of the remaining operand bits and passes
  // the still-unused upper bits forward, so the skew registers shrink by CW
  // per stage while the accumulated sum grows by CW.
  for (genvar k = 0; k < STAGES; k++) begin : stageGen
    localparam int REM = WIDTH - k * CW;

    logic [REM-1:0]      aIn;
    logic [REM-1:0]      bIn;
    logic                cIn;
    logic                vIn;
    logic                aMsbIn;
    logic                bMsbIn;
    logic [CW-1:0]       chunkSum;
    logic                chunkCarry;
    logic [(k+1)*CW-1:0] sNext;

    logic                vReg;
    logic                cReg;
    logic                aMsbReg;
    logic                bMsbReg;
    logic [(k+1)*CW-1:0] sReg;

    if (k == 0) begin : gHead
      assign aIn    = a;
      assign bIn    = bEff;
      assign cIn    = c0;
      assign vIn    = in_valid;
      assign aMsbIn = a[WIDTH-1];
      assign bMsbIn = bEff[WIDTH-1];
      assign sNext  = chunkSum;
    end else begin : gBody
      assign aIn    = stageGen[k-1].gRem.aRem;
      assign bIn    = stageGen[k-1].gRem.bRem;
      assign cIn    = stageGen[k-1].cReg;
      assign vIn    = stageGen[k-1].vReg;
      assign aMsbIn = stageGen[k-1].aMsbReg;
      assign bMsbIn = stageGen[k-1].bMsbReg;
      assign sNext  = {chunkSum, stageGen[k-1].sReg};
    end

    add_chunk #(.CW(CW)) uChunk (
      .a  (aIn[CW-1:0]),
      .b  (bIn[CW-1:0]),
      .ci (cIn),
      .s  (chunkSum),
      .co (chunkCarry)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        vReg    <= 1'b0;
        cReg    <= 1'b0;
        aMsbReg <= 1'b0;
        bMsbReg <= 1'b0;
        sReg    <= '0;
      end else if (adv) begin
        vReg    <= vIn;
        cReg    <= chunkCarry;
        aMsbReg <= aMsbIn;
        bMsbReg <= bMsbIn;
        sReg    <= sNext;
      end
    end

    if (k < STAGES - 1) begin : gRem
      logic [REM-CW-1:0] aRem;
      logic [REM-CW-1:0] bRem;

      always_ff @(posedge clk) begin
        if (rst) begin
          aRem <= '0;
          bRem <= '0;
        end else if (adv) begin
          aRem <= aIn[REM-1:CW];
          bRem <= bIn[REM-1:CW];
        end
      end
    end
  end

  assign out_valid = stageGen[STAGES-1].vReg;
  assign sum       = stageGen[STAGES-1].sReg;
  assign cout      = stageGen[STAGES-1].cReg;
  assign ovf       = (stageGen[STAGES-1].aMsbReg == stageGen[STAGES-1].bMsbReg) &&
                     (sum[WIDTH-1] != stageGen[STAGES-1].aMsbReg);

endmodule

// File: tb/tb_pipe_add_sub.sv
// Scoreboard bench for pipe_add_sub: directed arithmetic, backpressure, bubbles,
// mid-flight reset, and random sweeps of the 8/1 and 32/8 configurations.
module tb_pipe_add_sub;

  localparam int ST = 4;

  typedef struct {
    logic [63:0] expected;
    int          acceptCycle;
    int          holdMark;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic        s8v = 1'b0, s8inr, s8ov, s8rdy = 1'b1, s8cin = 1'b0, s8sub = 1'b0, s8co, s8ovf;
  logic [7:0]  s8a = '0, s8b = '0, s8sum;
  logic        s32v = 1'b0, s32inr, s32ov, s32rdy = 1'b1, s32cin = 1'b0, s32sub = 1'b0, s32co, s32ovf;
  logic [31:0] s32a = '0, s32b = '0, s32sum;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          holdCount = 0;
  int          sent8 = 0;
  int          sent32 = 0;
  bit          sweepOn = 1'b0;
  bit          randOn = 1'b0;
  entry_t      scb[$];
  logic [63:0] q8[$];
  logic [63:0] q32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  pipe_add_sub #(.WIDTH(16), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_add_sub #(.WIDTH(8), .STAGES(1)) u8 (
    .clk(clk), .rst(rst), .in_valid(s8v), .in_ready(s8inr), .a(s8a), .b(s8b),
    .cin(s8cin), .sub(s8sub), .out_valid(s8ov), .out_ready(s8rdy),
    .sum(s8sum), .cout(s8co), .ovf(s8ovf)
  );

  pipe_add_sub #(.WIDTH(32), .STAGES(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(s32v), .in_ready(s32inr), .a(s32a), .b(s32b),
    .cin(s32cin), .sub(s32sub), .out_valid(s32ov), .out_ready(s32rdy),
    .sum(s32sum), .cout(s32co), .ovf(s32ovf)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Flat full-width reference, packed as {ovf, cout, sum}.
  function automatic logic [63:0] refModel(input int w, input logic [31:0] ra, input logic [31:0] rb,
                                           input logic rcin, input logic rsub);
    logic [63:0] mask, aa, bb, full, s;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, ra} & mask;
    bb   = (rsub ? ~{32'd0, rb} : {32'd0, rb}) & mask;
    full = aa + bb + (rsub ? 64'd1 : {63'd0, rcin});
    s    = full & mask;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return ({63'd0, ov} << (w + 1)) | ({63'd0, co} << w) | s;
  endfunction

  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tbv, input logic tcin,
                               input logic tsub, input logic [63:0] texp);
    bit acc = 1'b0;
    int guard = 0;
    in_valid = 1'b1;
    a = ta;
    b = tbv;
    cin = tcin;
    sub = tsub;
    while (!acc && guard < 200) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        acc = 1'b1;
        scb.push_back('{expected: texp, acceptCycle: cycle, holdMark: holdCount});
      end
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (scb.size() != 0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput(tag, 64'(scb.size()), 64'd0);
  endtask

  task automatic randomBeat();
    logic [15:0] ra, rb;
    logic        rc, rs;
    ra = 16'($urandom);
    rb = 16'($urandom);
    rc = 1'($urandom);
    rs = 1'($urandom);
    applyStimulus(ra, rb, rc, rs, refModel(16, {16'd0, ra}, {16'd0, rb}, rc, rs));
  endtask

  // Main pipe monitor: ordered results, latency including stall cycles, held outputs.
  always @(negedge clk) begin
    if (rst) begin
      scb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (scb.size() == 0) begin
          checkOutput("unexpected_out", 64'd1, 64'd0);
        end else begin
          entry_t e;
          e = scb.pop_front();
          checkOutput("result", {61'd0, ovf, cout, sum}, e.expected);
          checkOutput("latency", 64'(cycle), 64'(e.acceptCycle + ST + (holdCount - e.holdMark)));
        end
      end
      if (out_valid && !out_ready) begin
        checkOutput("in_ready_stall", {63'd0, in_ready}, 64'd0);
        if (scb.size() == 0) checkOutput("unexpected_stall", 64'd1, 64'd0);
        else checkOutput("stall_hold", {61'd0, ovf, cout, sum}, scb[0].expected);
        holdCount++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (sweepOn) begin
      s8v    = (sent8 < 1000) && ($urandom_range(0, 3) != 0);
      s8a    = 8'($urandom);
      s8b    = 8'($urandom);
      s8cin  = 1'($urandom);
      s8sub  = 1'($urandom);
      s8rdy  = ($urandom_range(0, 3) != 0);
      s32v   = (sent32 < 1000) && ($urandom_range(0, 3) != 0);
      s32a   = $urandom;
      s32b   = $urandom;
      s32cin = 1'($urandom);
      s32sub = 1'($urandom);
      s32rdy = ($urandom_range(0, 3) != 0);
    end else begin
      s8v    = 1'b0;
      s8rdy  = 1'b1;
      s32v   = 1'b0;
      s32rdy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      q32.delete();
    end else begin
      if (s8ov && s8rdy) begin
        if (q8.size() == 0) checkOutput("sw8_unexpected", 64'd1, 64'd0);
        else checkOutput("sw8_result", {54'd0, s8ovf, s8co, s8sum}, q8.pop_front());
      end
      if (s8v && s8inr) begin
        q8.push_back(refModel(8, {24'd0, s8a}, {24'd0, s8b}, s8cin, s8sub));
        sent8++;
      end
      if (s32ov && s32rdy) begin
        if (q32.size() == 0) checkOutput("sw32_unexpected", 64'd1, 64'd0);
        else checkOutput("sw32_result", {30'd0, s32ovf, s32co, s32sum}, q32.pop_front());
      end
      if (s32v && s32inr) begin
        q32.push_back(refModel(32, s32a, s32b, s32cin, s32sub));
        sent32++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset_outputs", {61'd0, ovf, cout, sum}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(16'h0003, 16'h0005, 1'b0, 1'b0, 64'h0_0008);
    drain("drain_basic");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 64'h1_0000);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 64'h2_8000);
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 64'h0_FFFE);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 64'h3_7FFF);
    applyStimulus(16'h1234, 16'h1111, 1'b1, 1'b0, 64'h0_2346);
    applyStimulus(16'h0010, 16'h0001, 1'b1, 1'b1, 64'h1_000F);
    drain("drain_directed");

    fork
      begin
        repeat (8) randomBeat();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    applyStimulus(16'h0101, 16'h0202, 1'b0, 1'b0, 64'h0_0303);
    idle(2);
    applyStimulus(16'h1000, 16'h0001, 1'b0, 1'b0, 64'h0_1001);
    applyStimulus(16'h2000, 16'h0002, 1'b0, 1'b1, 64'h1_1FFE);
    applyStimulus(16'h3000, 16'h0003, 1'b1, 1'b0, 64'h0_3004);
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'h4444;
    b        = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("midreset_outputs", {61'd0, ovf, cout, sum}, 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(8);
    applyStimulus(16'h00F0, 16'h000F, 1'b0, 1'b0, 64'h0_00FF);
    drain("drain_after_reset");

    randOn = 1'b1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          randomBeat();
          if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end
        randOn = 1'b0;
      end
      begin
        while (randOn) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    sweepOn = 1'b1;
    guard = 0;
    while (!(sent8 >= 1000 && sent32 >= 1000 && q8.size() == 0 && q32.size() == 0) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    sweepOn = 1'b0;
    checkOutput("sweep8_count", 64'(sent8), 64'd1000);
    checkOutput("sweep32_count", 64'(sent32), 64'd1000);
    checkOutput("sweep_drain", 64'(q8.size() + q32.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
